// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: data width, idle line level, receiver FSM states
// and the even-parity helper used when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to
// the idle line level so the receiver never sees a false start after reset.
module uart_rx_sync
  import uart_rx_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic meta_q;
  logic sync_q;

  // Resolve metastability over two clock edges
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      meta_q <= UART_IDLE_LEVEL;
      sync_q <= UART_IDLE_LEVEL;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
    end
  end

  assign o_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Recovers bytes from the serial line and
// presents them on a valid/ready handshake with frame-error and sticky
// overrun flags. Define UART_RX_PARITY_EN to receive 8E1 frames and add the
// o_parity_err output; bytes with bad parity are dropped.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_signal,
  output logic [UART_DATA_W-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_frame_err,
  output logic                   o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   o_parity_err
`endif
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_state_e            state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   sample;

  // Frame-end events from the FSM, registered one stage before the outputs
  logic stop_good_d, stop_good_p0;
  logic stop_bad_d, stop_bad_p0;
`ifdef UART_RX_PARITY_EN
  logic parity_ok_q, parity_ok_d;
  logic par_bad_d, par_bad_p0;
`endif

  uart_rx_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_signal),
    .o_sync  (rx_s)
  );

  assign sample = (baud_q == '0);
  assign o_busy = (state_q != IDLE);

  // FSM next state, baud/bit counters and shift register updates
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    armed_d     = armed_q;
    stop_good_d = 1'b0;
    stop_bad_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
    par_bad_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A start is only accepted after the line has been seen high, so a
        // held-low break produces a single frame error rather than a stream.
        if (rx_s == UART_IDLE_LEVEL) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          baud_d  = HALF_LOAD;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_d = DATA;
            baud_d  = FULL_LOAD;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (sample) begin
          shift_d[idx_q] = rx_s;
          baud_d         = FULL_LOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          parity_ok_d = (rx_s == even_parity(shift_q));
          state_d     = STOP;
          baud_d      = FULL_LOAD;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
`endif
      STOP: begin
        // Leave as soon as the stop bit is sampled so a back-to-back start
        // bit arriving at the end of the stop period is not missed.
        if (sample) begin
          state_d = IDLE;
          armed_d = 1'b0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            stop_good_d = parity_ok_q;
            par_bad_d   = !parity_ok_q;
`else
            stop_good_d = 1'b1;
`endif
          end else begin
            stop_bad_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      idx_q        <= '0;
      armed_q      <= 1'b0;
      stop_good_p0 <= 1'b0;
      stop_bad_p0  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok_q  <= 1'b0;
      par_bad_p0   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      idx_q        <= idx_d;
      armed_q      <= armed_d;
      stop_good_p0 <= stop_good_d;
      stop_bad_p0  <= stop_bad_d;
`ifdef UART_RX_PARITY_EN
      parity_ok_q  <= parity_ok_d;
      par_bad_p0   <= par_bad_d;
`endif
    end
  end

  // Shift register holds data only; a partial byte is simply overwritten
  always_ff @(posedge i_clock) begin
    shift_q <= shift_d;
  end

  // ---- stage p0 -> outputs: handshake, overrun and error pulses ----
  // Output register: load a completed byte, clear on acceptance, flag overrun
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= stop_bad_p0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= par_bad_p0;
`endif
      if (stop_good_p0) begin
        // Accepting the held byte in this same cycle frees room for the new one
        if (!o_valid || i_ready) begin
          o_data  <= shift_q;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (CLKS_PER_BIT=16). Frames are driven with a
// bit-accurate serial model; expected bytes go into a scoreboard queue and are
// compared whenever the DUT hands a byte over (o_valid && i_ready).
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam int LAT   = 2 + HALF + 9 * CPB + 1 + CPB;
`else
  localparam int NBITS = 10;
  localparam int LAT   = 2 + HALF + 9 * CPB + 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       line = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_overrun;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
  int         perr_cnt = 0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int valid_hi = 0;
  int ferr_cnt = 0;
  logic valid_d = 1'b0;
  logic [7:0] sb[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_signal    (line),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor on the falling edge: event counters and scoreboard compare
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (o_valid && !valid_d) rise_cyc = cyc;
      if (o_valid) valid_hi++;
      if (o_frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (o_parity_err) perr_cnt++;
`endif
      if (o_valid && i_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got byte %02h, expected none", o_data);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (o_data !== e) begin
            bad++;
            $display("FAIL sb_data: got %02h, expected %02h", o_data, e);
          end
        end
      end
    end
    valid_d = o_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {stop, ^d, d, 1'b0};
`else
    return {1'b0, stop, d, 1'b0};
`endif
  endfunction

  // Drive bits LSB first, each held for one bit period
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      line = fr[i];
      if (i == 0) start_cyc = cyc + 1;
      repeat (CPB) tick();
    end
    line = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];
  int   v0, f0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'h5A, 1'b1, 1, 0};
    vecs[5] = '{8'hFF, 1'b0, 0, 1};
    vecs[6] = '{8'h12, 1'b1, 1, 0};

    // Reset and idle line
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    check("idle_valid", int'(o_valid), 0);
    check("idle_busy", int'(o_busy), 0);
    check("idle_ferr", int'(o_frame_err), 0);
    check("idle_overrun", int'(o_overrun), 0);
    check("idle_data", int'(o_data), 0);
    check("idle_events", valid_hi + ferr_cnt, 0);

    // Table: single frames with the consumer always ready
    for (int k = 0; k < 7; k++) begin
      v0 = valid_hi;
      f0 = ferr_cnt;
      rise_cyc = -1;
      if (vecs[k].exp_valid != 0) sb.push_back(vecs[k].data);
      send_bits(frame_of(vecs[k].data, vecs[k].stop), NBITS);
      repeat (4) tick();
      check($sformatf("vec%0d_valid_cycles", k), valid_hi - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_frame_err", k), ferr_cnt - f0, vecs[k].exp_ferr);
      if (k == 0) check("latency", rise_cyc - start_cyc, LAT);
    end

    // Back-to-back frames with no consumer: second byte overruns
    i_ready = 1'b0;
    v0 = valid_hi;
    sb.push_back(8'h3C);
    send_bits(frame_of(8'h3C, 1'b1), NBITS);
    send_bits(frame_of(8'hC3, 1'b1), NBITS);
    repeat (4) tick();
    check("ovr_valid", int'(o_valid), 1);
    check("ovr_data", int'(o_data), 8'h3C);
    check("ovr_flag", int'(o_overrun), 1);
    i_ready = 1'b1;
    tick();
    tick();
    check("ovr_valid_fall", int'(o_valid), 0);
    check("ovr_sticky", int'(o_overrun), 1);

    // Short low glitch on an idle line is rejected
    v0 = valid_hi;
    f0 = ferr_cnt;
    line = 1'b0;
    repeat (5) tick();
    check("glitch_busy_rise", int'(o_busy), 1);
    line = 1'b1;
    repeat (30) tick();
    check("glitch_busy_fall", int'(o_busy), 0);
    check("glitch_events", (valid_hi - v0) + (ferr_cnt - f0), 0);

    // Reset during data bit 4 of 0x55
    line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      line = (i % 2 == 0);
      repeat (CPB) tick();
    end
    line = 1'b1;
    repeat (HALF) tick();
    check("mid_busy", int'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", int'(o_busy), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_ferr", int'(o_frame_err), 0);
    repeat (10) tick();
    v0 = valid_hi;
    sb.push_back(8'h81);
    send_bits(frame_of(8'h81, 1'b1), NBITS);
    repeat (4) tick();
    check("post_rst_valid_cycles", valid_hi - v0, 1);

`ifdef UART_RX_PARITY_EN
    // Wrong parity drops the byte; correct parity delivers it
    v0 = valid_hi;
    f0 = perr_cnt;
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, NBITS);
    repeat (4) tick();
    check("par_bad_pulse", perr_cnt - f0, 1);
    check("par_bad_no_valid", valid_hi - v0, 0);
    sb.push_back(8'h07);
    send_bits(frame_of(8'h07, 1'b1), NBITS);
    repeat (4) tick();
    check("par_good_valid", valid_hi - v0, 1);
    check("par_good_no_err", perr_cnt - f0, 1);
`endif

    repeat (10) tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
